signal_sched: RTL and testbench

Round-robin scheduler that shares one rotating serial-pattern generator between `NUM_REQ` requesters. Each requester presents a `DATA_WIDTH`-bit pattern and a repeat count. The block grants one requester at a time, loads that pattern into the internal rotating register, and plays it out MSB-first for `reps+1` full rotations. It then signals completion and re-arbitrates. It sits between pattern-producing clients and the serial signal output pin.

---
 rtl/signal_sched_pkg.sv | 16 +
 rtl/rot_shift_reg.sv | 37 +++
 rtl/signal_sched.sv | 151 +++++++++++++++
 tb/tb_signal_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/signal_sched_pkg.sv
// signal_sched_pkg
// Shared types and defaults for the signal_sched round-robin pattern scheduler.
//   state_t               : scheduler FSM states
//   DEFAULT_RESET_PATTERN : rotating-register contents after reset
package signal_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] DEFAULT_RESET_PATTERN = 6'b110011;

endpackage : signal_sched_pkg

// File: rtl/rot_shift_reg.sv
// rot_shift_reg
// Rotating pattern register; rotates left so the MSB is presented first and
// wraps around into the LSB.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RESET_PATTERN
//   load  : parallel load of d (has priority over en)
//   en    : rotate left by one bit
//   d     : parallel load data
//   q_msb : current register MSB
module rot_shift_reg #(
  parameter int                    DATA_WIDTH    = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  q_msb
);

  logic [DATA_WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PATTERN;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= {q[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
    end
  end

  assign q_msb = q[DATA_WIDTH-1];

endmodule : rot_shift_reg

// File: rtl/signal_sched.sv
// signal_sched
// Round-robin scheduler sharing one rotating serial-pattern generator among
// NUM_REQ clients. The granted pattern plays MSB-first for reps+1 rotations.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-client request (level, held until gnt)
//   pattern    : client i pattern at [i*DATA_WIDTH +: DATA_WIDTH]
//   reps       : client i repeat count at [i*REP_WIDTH +: REP_WIDTH]
//   gnt        : registered one-hot grant
//   out        : serial bit (0 when out_valid is low)
//   out_valid  : out carries pattern data
//   busy       : scheduler is in LOAD, PLAY or DONE
//   done       : one-cycle pulse at end of playout
module signal_sched
  import signal_sched_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 6,
  parameter int                    NUM_REQ       = 4,
  parameter int                    REP_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PATTERN = DATA_WIDTH'(DEFAULT_RESET_PATTERN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   pattern,
  input  logic [NUM_REQ*REP_WIDTH-1:0]    reps,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            out,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      winner, last, pick;
  logic                  found;
  logic [BW-1:0]         bit_cnt;
  logic [REP_WIDTH-1:0]  rep_cnt;
  logic                  last_bit;
  logic                  q_msb;
  logic [DATA_WIDTH-1:0] pat_arr [NUM_REQ];
  logic [REP_WIDTH-1:0]  rep_arr [NUM_REQ];

  // Unpack the flat client buses so the winner can index them directly.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pat_arr[i] = pattern[i*DATA_WIDTH +: DATA_WIDTH];
      rep_arr[i] = reps[i*REP_WIDTH +: REP_WIDTH];
    end
  end

  // Round-robin pick: first requester above last, else wrap to the lowest.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
  end

  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the playout ends only after the final rotation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (found) state_d = LOAD;
      LOAD: state_d = PLAY;
      PLAY: if (last_bit && (rep_cnt == '0)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, arbitration history and playout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      winner  <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
      bit_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            winner <= pick;
            gnt    <= NUM_REQ'(1) << pick;
          end
        end
        LOAD: begin
          bit_cnt <= '0;
          rep_cnt <= rep_arr[winner];
        end
        PLAY: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (rep_cnt != '0) rep_cnt <= rep_cnt - REP_WIDTH'(1);
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DONE: begin
          last <= winner;
          gnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  rot_shift_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .RESET_PATTERN (RESET_PATTERN)
  ) u_rot (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == LOAD),
    .en    (state_q == PLAY),
    .d     (pat_arr[winner]),
    .q_msb (q_msb)
  );

  // Outputs decode straight from registered state.
  assign out_valid = (state_q == PLAY);
  assign out       = out_valid & q_msb;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule : signal_sched

// File: tb/tb_signal_sched.sv
// tb_signal_sched
// Directed self-checking bench for signal_sched with default parameters.
module tb_signal_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] pattern;
  logic [15:0] reps;
  logic [3:0]  gnt;
  logic        out;
  logic        out_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  signal_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pattern   (pattern),
    .reps      (reps),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic setClient(input int i, input logic [5:0] p, input logic [3:0] r);
    pattern[i*6 +: 6] = p;
    reps[i*4 +: 4]    = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete grant: entered in the IDLE cycle whose edge samples req.
  task automatic playCheck(input int client, input logic [5:0] pat, input int rp,
                           input logic [3:0] reqAfter, input bit mangle);
    logic [5:0] p;
    p = pat;
    tick();
    checkOutput("gnt_load", {28'd0, gnt}, 32'd1 << client);
    checkOutput("load_flags", {29'd0, busy, out_valid, done}, 32'b100);
    applyStimulus(reqAfter);
    for (int j = 0; j < (rp + 1) * 6; j++) begin
      tick();
      if (mangle && j == 2) begin
        setClient(client, ~pat, 4'hF);
        req[client] = 1'b0;
      end
      checkOutput("play_bit", {30'd0, out_valid, out}, {30'd0, 1'b1, p[5 - (j % 6)]});
    end
    tick();
    checkOutput("done_flags", {29'd0, done, out_valid, busy}, 32'b101);
    checkOutput("gnt_done", {28'd0, gnt}, 32'd1 << client);
    tick();
    checkOutput("idle_flags", {26'd0, gnt, busy, done}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    pattern = '0;
    reps    = '0;
    #1;
    checkOutput("reset_out", {27'd0, gnt, out}, 32'd0);
    checkOutput("reset_flags", {29'd0, out_valid, busy, done}, 32'd0);
    #12 rst_n = 1'b1;

    // Single request, no repeat.
    $display("[TB] single request");
    setClient(0, 6'b101100, 4'd0);
    applyStimulus(4'b0001);
    playCheck(0, 6'b101100, 0, 4'b0000, 1'b0);

    // Repeat count on client 2.
    $display("[TB] repeat count");
    setClient(2, 6'b100000, 4'd2);
    applyStimulus(4'b0100);
    playCheck(2, 6'b100000, 2, 4'b0000, 1'b0);

    // Reset during the third bit of client 3's playout.
    $display("[TB] reset mid-play");
    setClient(3, 6'b111111, 4'd1);
    applyStimulus(4'b1000);
    tick();
    checkOutput("gnt_c3", {28'd0, gnt}, 32'b1000);
    applyStimulus(4'b0000);
    tick();
    tick();
    tick();
    checkOutput("bit3_valid", {30'd0, out_valid, out}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_flags", {28'd0, out_valid, out, busy, done}, 32'd0);
    tick();
    checkOutput("rst_hold", {29'd0, busy, out_valid, done}, 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("post_rst_idle", {26'd0, gnt, busy, done}, 32'd0);
    end

    // Fairness with all clients requesting; client 0 must win first.
    $display("[TB] fairness");
    setClient(0, 6'b100101, 4'd0);
    setClient(1, 6'b011010, 4'd0);
    setClient(2, 6'b111000, 4'd0);
    setClient(3, 6'b000111, 4'd0);
    applyStimulus(4'b1111);
    playCheck(0, 6'b100101, 0, 4'b1111, 1'b0);
    playCheck(1, 6'b011010, 0, 4'b1111, 1'b0);
    playCheck(2, 6'b111000, 0, 4'b1111, 1'b0);
    playCheck(3, 6'b000111, 0, 4'b1111, 1'b0);
    playCheck(0, 6'b100101, 0, 4'b0000, 1'b0);

    // Input changes after LOAD must not affect client 1's playout.
    $display("[TB] input stability");
    setClient(1, 6'b110100, 4'd1);
    applyStimulus(4'b0010);
    playCheck(1, 6'b110100, 1, 4'b0010, 1'b1);

    // Maximum repeat count gives 96 valid bits.
    $display("[TB] max repeat");
    setClient(2, 6'b101001, 4'hF);
    applyStimulus(4'b0100);
    playCheck(2, 6'b101001, 15, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_signal_sched
